// File: rtl/dvi_scanout_ctrl.sv
// DVI scanout controller: fetches framebuffer pixels in bursts into a small FIFO
// and plays them out against an external timing generator, flagging starvation.
module dvi_scanout_ctrl #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int BURST    = 16,
  parameter int DEPTH    = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] frame_base,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [23:0] mem_rdata,
  input  logic        ve_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        ve,
  output logic        hsync,
  output logic        vsync,
  output logic        busy,
  output logic        underflow
);

  localparam int              AW         = $clog2(DEPTH);
  localparam int              BCW        = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [19:0]     TOTAL_PX   = 20'(H_ACTIVE * V_ACTIVE);
  localparam logic [19:0]     BURST_PX   = 20'(BURST);
  localparam logic [AW:0]     FILL_LIMIT = (AW + 1)'(DEPTH - BURST);
  localparam logic [BCW-1:0]  LAST_BEAT  = BCW'(BURST - 1);
  localparam logic [23:0]     MAGENTA    = 24'hFF00FF;
  localparam logic [23:0]     BLACK      = 24'h000000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    RUN       = 2'd2,
    WAIT_DATA = 2'd3
  } state_t;

  state_t         state_r;
  state_t         state_n;
  logic [31:0]    base_r;
  logic [19:0]    fetch_r;
  logic [BCW-1:0] beat_cnt_r;
  logic           mem_req_r;
  logic [31:0]    mem_addr_r;
  logic           vs_hist_r;
  logic           vs_pend_r;
  logic           stop_pend_r;
  logic           busy_r;
  logic           underflow_r;
  logic [23:0]    pix_r;
  logic           ve_r;
  logic           hsync_r;
  logic           vsync_r;

  logic [23:0]    fifo_mem_r [DEPTH];
  logic [AW:0]    wr_ptr_r;
  logic [AW:0]    rd_ptr_r;
  logic [AW:0]    count_s;
  logic           empty_s;
  logic           active_s;
  logic           pop_s;
  logic           starve_s;
  logic           vs_fall_s;

  logic           frame_evt_s;
  logic           restart_s;
  logic           flush_s;
  logic           req_set_s;
  logic           req_clr_s;
  logic           push_s;
  logic           beat_inc_s;
  logic           burst_done_s;
  logic           vs_pend_set_s;

  assign count_s   = wr_ptr_r - rd_ptr_r;
  assign empty_s   = (count_s == {(AW + 1){1'b0}});
  assign active_s  = (state_r == RUN) || (state_r == WAIT_DATA);
  assign pop_s     = active_s && ve_in && !empty_s;
  assign starve_s  = active_s && ve_in && empty_s;
  assign vs_fall_s = vs_hist_r && !vsync_in;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state decode and datapath strobes
  always_comb begin
    state_n       = state_r;
    frame_evt_s   = 1'b0;
    restart_s     = 1'b0;
    flush_s       = 1'b0;
    req_set_s     = 1'b0;
    req_clr_s     = 1'b0;
    push_s        = 1'b0;
    beat_inc_s    = 1'b0;
    burst_done_s  = 1'b0;
    vs_pend_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_n = ARM;
        end else begin
          state_n = IDLE;
        end
      end
      ARM: begin
        if (vs_fall_s) begin
          frame_evt_s = 1'b1;
        end else begin
          frame_evt_s = 1'b0;
        end
      end
      RUN: begin
        // An accepted request wins over a same-cycle vsync edge; the edge is then deferred
        if (mem_req_r && mem_ack) begin
          req_clr_s     = 1'b1;
          state_n       = WAIT_DATA;
          vs_pend_set_s = vs_fall_s;
        end else if (vs_fall_s) begin
          req_clr_s   = 1'b1;
          frame_evt_s = 1'b1;
        end else if (!mem_req_r && (fetch_r < TOTAL_PX) && (count_s <= FILL_LIMIT)) begin
          req_set_s = 1'b1;
        end else begin
          req_set_s = 1'b0;
        end
      end
      WAIT_DATA: begin
        vs_pend_set_s = vs_fall_s;
        if (mem_rvalid) begin
          if (beat_cnt_r == LAST_BEAT) begin
            if (vs_pend_r || vs_fall_s) begin
              frame_evt_s = 1'b1;
            end else begin
              push_s       = 1'b1;
              burst_done_s = 1'b1;
              state_n      = RUN;
            end
          end else begin
            push_s     = 1'b1;
            beat_inc_s = 1'b1;
          end
        end else begin
          push_s = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (frame_evt_s) begin
      flush_s = 1'b1;
      if (stop_pend_r || stop) begin
        state_n = IDLE;
      end else begin
        restart_s = 1'b1;
        state_n   = RUN;
      end
    end else begin
      flush_s = 1'b0;
    end
  end

  // Fetch bookkeeping, memory request port and pending flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      base_r      <= 32'h0000_0000;
      fetch_r     <= 20'd0;
      beat_cnt_r  <= {BCW{1'b0}};
      mem_req_r   <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      vs_hist_r   <= 1'b1;
      vs_pend_r   <= 1'b0;
      stop_pend_r <= 1'b0;
      busy_r      <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      vs_hist_r <= vsync_in;
      busy_r    <= (state_n != IDLE);
      if (restart_s) begin
        base_r  <= frame_base;
        fetch_r <= 20'd0;
      end else if (burst_done_s) begin
        fetch_r <= fetch_r + BURST_PX;
      end
      if (beat_inc_s) begin
        beat_cnt_r <= beat_cnt_r + BCW'(1);
      end else if (state_r != WAIT_DATA || push_s || frame_evt_s) begin
        beat_cnt_r <= {BCW{1'b0}};
      end
      if (req_set_s) begin
        mem_req_r  <= 1'b1;
        mem_addr_r <= base_r + {10'd0, fetch_r, 2'b00};
      end else if (req_clr_s) begin
        mem_req_r <= 1'b0;
      end
      if (frame_evt_s) begin
        vs_pend_r <= 1'b0;
      end else if (vs_pend_set_s) begin
        vs_pend_r <= 1'b1;
      end
      if (frame_evt_s && state_n == IDLE) begin
        stop_pend_r <= 1'b0;
      end else if (stop && state_r != IDLE) begin
        stop_pend_r <= 1'b1;
      end
      if (start) begin
        underflow_r <= 1'b0;
      end else if (starve_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  // Pixel FIFO pointers; a flush overrides any same-cycle push or pop
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_r <= {(AW + 1){1'b0}};
      rd_ptr_r <= {(AW + 1){1'b0}};
    end else if (flush_s) begin
      wr_ptr_r <= {(AW + 1){1'b0}};
      rd_ptr_r <= {(AW + 1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + (AW + 1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW + 1)'(1);
      end
    end
  end

  // Pixel FIFO storage
  always_ff @(posedge clock) begin
    if (reset && push_s) begin
      fifo_mem_r[wr_ptr_r[AW-1:0]] <= mem_rdata;
    end
  end

  // Pixel and timing output stage
  always_ff @(posedge clock) begin
    if (!reset) begin
      pix_r   <= BLACK;
      ve_r    <= 1'b0;
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
    end else begin
      ve_r    <= ve_in;
      hsync_r <= hsync_in;
      vsync_r <= vsync_in;
      if (pop_s) begin
        pix_r <= fifo_mem_r[rd_ptr_r[AW-1:0]];
      end else if (starve_s) begin
        pix_r <= MAGENTA;
      end else begin
        pix_r <= BLACK;
      end
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_addr  = mem_addr_r;
  assign red       = pix_r[23:16];
  assign green     = pix_r[15:8];
  assign blue      = pix_r[7:0];
  assign ve        = ve_r;
  assign hsync     = hsync_r;
  assign vsync     = vsync_r;
  assign busy      = busy_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_dvi_scanout_ctrl.sv
// Directed bench for dvi_scanout_ctrl with a small geometry (8x4, bursts of 4, FIFO of 8).
module tb_dvi_scanout_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [31:0] frame_base;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [23:0] mem_rdata;
  logic        ve_in;
  logic        hsync_in;
  logic        vsync_in;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        ve;
  logic        hsync;
  logic        vsync;
  logic        busy;
  logic        underflow;
  logic [23:0] rgb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;
  assign rgb = {red, green, blue};

  dvi_scanout_ctrl #(
    .H_ACTIVE(8), .V_ACTIVE(4), .BURST(4), .DEPTH(8)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .frame_base(frame_base),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ve_in(ve_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red(red), .green(green), .blue(blue), .ve(ve), .hsync(hsync), .vsync(vsync),
    .busy(busy), .underflow(underflow)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic [23:0] d);
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic ack_once();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_eq({tag, "_req"}, 32'(mem_req), 32'd0);
    chk_eq({tag, "_addr"}, mem_addr, 32'h0);
    chk_eq({tag, "_rgb"}, 32'(rgb), 32'h0);
    chk_eq({tag, "_ve"}, 32'(ve), 32'd0);
    chk_eq({tag, "_hs"}, 32'(hsync), 32'd1);
    chk_eq({tag, "_vs"}, 32'(vsync), 32'd1);
    chk_eq({tag, "_busy"}, 32'(busy), 32'd0);
    chk_eq({tag, "_uf"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; frame_base = 32'h0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 24'h0;
    ve_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    tick();
    tick();
    chk_reset_vals("rst");
    hsync_in = 1'b1; vsync_in = 1'b1;
    reset = 1'b1;
    tick();

    // Arm, then first request at the latched base
    pulse_start();
    chk_eq("armed_busy", 32'(busy), 32'd1);
    chk_eq("armed_noreq", 32'(mem_req), 32'd0);
    frame_base = 32'h0000_1000;
    vsync_in   = 1'b0;
    tick();
    chk_eq("vsync_aligned", 32'(vsync), 32'd0);
    tick();
    chk_eq("req1", 32'(mem_req), 32'd1);
    chk_eq("addr1", mem_addr, 32'h0000_1000);
    tick();
    chk_eq("req1_hold", 32'(mem_req), 32'd1);
    chk_eq("addr1_hold", mem_addr, 32'h0000_1000);
    ack_once();
    chk_eq("req1_drop", 32'(mem_req), 32'd0);
    vsync_in = 1'b1;
    for (int i = 1; i <= 4; i++) beat(24'(i));
    tick();
    chk_eq("req2", 32'(mem_req), 32'd1);
    chk_eq("addr2", mem_addr, 32'h0000_1010);
    ack_once();
    for (int i = 5; i <= 8; i++) beat(24'(i));
    tick();
    tick();
    chk_eq("fifo_full_noreq", 32'(mem_req), 32'd0);

    // Play out eight pixels in order
    ve_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk_eq($sformatf("pix%0d", i), 32'(rgb), 32'(i));
      chk_eq($sformatf("ve%0d", i), 32'(ve), 32'd1);
    end
    ve_in = 1'b0;
    tick();
    chk_eq("blank_rgb", 32'(rgb), 32'h0);
    chk_eq("blank_ve", 32'(ve), 32'd0);
    chk_eq("no_uf", 32'(underflow), 32'd0);
    chk_eq("req3", 32'(mem_req), 32'd1);
    chk_eq("addr3", mem_addr, 32'h0000_1020);

    // Starvation while the request is held off
    ve_in = 1'b1;
    tick();
    ve_in = 1'b0;
    chk_eq("magenta", 32'(rgb), 32'h00FF_00FF);
    chk_eq("uf_set", 32'(underflow), 32'd1);
    tick();
    chk_eq("uf_sticky", 32'(underflow), 32'd1);
    chk_eq("uf_black", 32'(rgb), 32'h0);
    pulse_start();
    chk_eq("uf_cleared", 32'(underflow), 32'd0);
    chk_eq("start_busy_ign", 32'(busy), 32'd1);
    chk_eq("req3_hold", mem_addr, 32'h0000_1020);

    // vsync falls mid-burst: restart on the last beat
    ack_once();
    beat(24'h000009);
    beat(24'h00000A);
    frame_base = 32'h0000_2000;
    vsync_in   = 1'b0;
    tick();
    beat(24'h00000B);
    beat(24'h00000C);
    chk_eq("restart_busy", 32'(busy), 32'd1);
    chk_eq("restart_noreq", 32'(mem_req), 32'd0);
    tick();
    chk_eq("req_newbase", 32'(mem_req), 32'd1);
    chk_eq("addr_newbase", mem_addr, 32'h0000_2000);
    vsync_in = 1'b1;
    ve_in    = 1'b1;
    tick();
    ve_in = 1'b0;
    chk_eq("flushed_magenta", 32'(rgb), 32'h00FF_00FF);
    pulse_start();
    chk_eq("uf_cleared2", 32'(underflow), 32'd0);

    // Stop: keep fetching until the next frame edge, then go idle
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_eq("stop_busy", 32'(busy), 32'd1);
    ack_once();
    for (int i = 0; i < 4; i++) beat(24'(8'hA0 + i));
    tick();
    chk_eq("stop_req_next", 32'(mem_req), 32'd1);
    chk_eq("stop_addr_next", mem_addr, 32'h0000_2010);
    vsync_in = 1'b0;
    tick();
    chk_eq("stop_idle", 32'(busy), 32'd0);
    chk_eq("stop_req_drop", 32'(mem_req), 32'd0);
    vsync_in = 1'b1;
    tick();
    tick();
    chk_eq("stop_no_req", 32'(mem_req), 32'd0);
    ve_in = 1'b1;
    tick();
    ve_in = 1'b0;
    chk_eq("idle_black", 32'(rgb), 32'h0);
    chk_eq("idle_no_uf", 32'(underflow), 32'd0);

    // One-cycle reset while a request is outstanding
    pulse_start();
    frame_base = 32'h0000_3000;
    vsync_in   = 1'b0;
    tick();
    tick();
    chk_eq("req_pre_rst", 32'(mem_req), 32'd1);
    chk_eq("addr_pre_rst", mem_addr, 32'h0000_3000);
    hsync_in = 1'b0;
    ve_in    = 1'b1;
    reset    = 1'b0;
    tick();
    chk_reset_vals("mid_rst");
    reset = 1'b1;
    ve_in = 1'b0;
    beat(24'h000055);
    chk_eq("post_rst_req", 32'(mem_req), 32'd0);
    chk_eq("post_rst_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
